// File: rtl/video_timing_pkg.sv
// Shared timing-set type, reset timing (320x240 active inside 450x270) and set validation.
package video_timing_pkg;

  localparam int TW = 16;

  typedef struct packed {
    logic [TW-1:0] h_total;
    logic [TW-1:0] h_bstart;
    logic [TW-1:0] h_sstart;
    logic [TW-1:0] h_send;
    logic [TW-1:0] v_total;
    logic [TW-1:0] v_bstart;
    logic [TW-1:0] v_sstart;
    logic [TW-1:0] v_send;
  } timing_set_t;

  localparam logic [TW-1:0] H_TOTAL_DEF  = 16'd450;
  localparam logic [TW-1:0] H_BSTART_DEF = 16'd320;
  localparam logic [TW-1:0] H_SSTART_DEF = 16'd360;
  localparam logic [TW-1:0] H_SEND_DEF   = 16'd380;
  localparam logic [TW-1:0] V_TOTAL_DEF  = 16'd270;
  localparam logic [TW-1:0] V_BSTART_DEF = 16'd240;
  localparam logic [TW-1:0] V_SSTART_DEF = 16'd250;
  localparam logic [TW-1:0] V_SEND_DEF   = 16'd253;

  localparam timing_set_t TIMING_DEF = '{
    h_total:  H_TOTAL_DEF,  h_bstart: H_BSTART_DEF,
    h_sstart: H_SSTART_DEF, h_send:   H_SEND_DEF,
    v_total:  V_TOTAL_DEF,  v_bstart: V_BSTART_DEF,
    v_sstart: V_SSTART_DEF, v_send:   V_SEND_DEF
  };

  // A set is usable only if blank < sync start < sync end < total on both axes.
  function automatic logic set_ok(input timing_set_t t);
    return (t.h_bstart < t.h_sstart) && (t.h_sstart < t.h_send) && (t.h_send < t.h_total) &&
           (t.v_bstart < t.v_sstart) && (t.v_sstart < t.v_send) && (t.v_send < t.v_total);
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One timing axis: position counter with registered blank/sync decode aligned to the count.
module vtg_axis_counter #(
  parameter int W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              inc,
  input  logic [W-1:0]      total,
  input  logic [W-1:0]      bstart,
  input  logic [W-1:0]      sstart,
  input  logic [W-1:0]      send,
  input  logic signed [3:0] offset,
  output logic [W-1:0]      cnt,
  output logic [W-1:0]      cnt_nxt,
  output logic              blank,
  output logic              blank_nxt,
  output logic              sync,
  output logic              last
);

  logic              adv;
  logic              sync_nxt;
  logic signed [W:0] pos;
  logic signed [W:0] win_lo;
  logic signed [W:0] win_hi;
  logic signed [W:0] off_ext;

  assign adv  = ce & inc;
  assign last = (cnt == total - W'(1));

  always_comb begin
    cnt_nxt = cnt;
    if (adv) cnt_nxt = last ? '0 : cnt + W'(1);
  end

  // Decode is done on the value the counter is about to take so the
  // registered blank/sync line up with the registered count.
  assign off_ext   = {{(W-3){offset[3]}}, offset};
  assign pos       = $signed({1'b0, cnt_nxt});
  assign win_lo    = $signed({1'b0, sstart}) + off_ext;
  assign win_hi    = $signed({1'b0, send}) + off_ext;
  assign blank_nxt = (cnt_nxt >= bstart);
  assign sync_nxt  = !((pos >= win_lo) && (pos < win_hi));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      blank <= 1'b0;
      sync  <= 1'b1;
    end else if (adv) begin
      cnt   <= cnt_nxt;
      blank <= blank_nxt;
      sync  <= sync_nxt;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with frame-synchronous timing-set reload and sync trims.
// Optional interlace-style field output is enabled by defining VTG_FIELD_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HW = 10,
  parameter int VW = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [HW-1:0]     cfg_h_total,
  input  logic [HW-1:0]     cfg_h_bstart,
  input  logic [HW-1:0]     cfg_h_sstart,
  input  logic [HW-1:0]     cfg_h_send,
  input  logic [VW-1:0]     cfg_v_total,
  input  logic [VW-1:0]     cfg_v_bstart,
  input  logic [VW-1:0]     cfg_v_sstart,
  input  logic [VW-1:0]     cfg_v_send,
  input  logic signed [3:0] hs_offset,
  input  logic signed [3:0] vs_offset,
  output logic              cfg_err,
  output logic [HW-1:0]     hc,
  output logic [VW-1:0]     vc,
  output logic              hblank,
  output logic              vblank,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              line_start,
  output logic              frame_start
`ifdef VTG_FIELD_EN
  ,
  output logic              field
`endif
);

  typedef struct packed {
    logic [HW-1:0] h_total;
    logic [HW-1:0] h_bstart;
    logic [HW-1:0] h_sstart;
    logic [HW-1:0] h_send;
    logic [VW-1:0] v_total;
    logic [VW-1:0] v_bstart;
    logic [VW-1:0] v_sstart;
    logic [VW-1:0] v_send;
  } tset_t;

  localparam tset_t DEF_SET = '{
    h_total:  TIMING_DEF.h_total[HW-1:0],  h_bstart: TIMING_DEF.h_bstart[HW-1:0],
    h_sstart: TIMING_DEF.h_sstart[HW-1:0], h_send:   TIMING_DEF.h_send[HW-1:0],
    v_total:  TIMING_DEF.v_total[VW-1:0],  v_bstart: TIMING_DEF.v_bstart[VW-1:0],
    v_sstart: TIMING_DEF.v_sstart[VW-1:0], v_send:   TIMING_DEF.v_send[VW-1:0]
  };

  timing_set_t       offer_w;
  tset_t             offer_n;
  tset_t             act;
  tset_t             pend;
  tset_t             nxt;
  logic              cfg_ok;
  logic              offer_fire;
  logic              h_last;
  logic              v_last;
  logic              frame_wrap;
  logic              apply;
  logic signed [3:0] hs_off_q;
  logic signed [3:0] vs_off_q;
  logic signed [3:0] hs_off_nxt;
  logic signed [3:0] vs_off_nxt;
  logic [HW-1:0]     hc_nxt;
  logic [VW-1:0]     vc_nxt;
  logic [VW-1:0]     v_total_eff;
  logic              hblank_nxt;
  logic              vblank_nxt;

  assign offer_w = '{
    h_total:  TW'(cfg_h_total),  h_bstart: TW'(cfg_h_bstart),
    h_sstart: TW'(cfg_h_sstart), h_send:   TW'(cfg_h_send),
    v_total:  TW'(cfg_v_total),  v_bstart: TW'(cfg_v_bstart),
    v_sstart: TW'(cfg_v_sstart), v_send:   TW'(cfg_v_send)
  };
  assign offer_n = '{cfg_h_total, cfg_h_bstart, cfg_h_sstart, cfg_h_send,
                     cfg_v_total, cfg_v_bstart, cfg_v_sstart, cfg_v_send};

  assign cfg_ok     = set_ok(offer_w);
  assign offer_fire = cfg_valid & cfg_ready;
  assign frame_wrap = ce_pix & h_last & v_last;
  assign apply      = frame_wrap & ~cfg_ready;

  // Decode for the position after this edge must already see the set and
  // trims that take effect at a frame wrap.
  assign nxt        = apply ? pend : act;
  assign hs_off_nxt = frame_wrap ? hs_offset : hs_off_q;
  assign vs_off_nxt = frame_wrap ? vs_offset : vs_off_q;

`ifdef VTG_FIELD_EN
  assign v_total_eff = act.v_total + VW'(field);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        field <= 1'b0;
    else if (frame_wrap) field <= ~field;
  end
`else
  assign v_total_eff = act.v_total;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act       <= DEF_SET;
      pend      <= DEF_SET;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      hs_off_q  <= '0;
      vs_off_q  <= '0;
    end else begin
      cfg_err <= offer_fire & ~cfg_ok;
      if (offer_fire && cfg_ok) begin
        pend      <= offer_n;
        cfg_ready <= 1'b0;
      end else if (apply) begin
        act       <= pend;
        cfg_ready <= 1'b1;
      end
      if (frame_wrap) begin
        hs_off_q <= hs_offset;
        vs_off_q <= vs_offset;
      end
    end
  end

  vtg_axis_counter #(.W(HW)) u_h (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce_pix),
    .inc       (1'b1),
    .total     (act.h_total),
    .bstart    (nxt.h_bstart),
    .sstart    (nxt.h_sstart),
    .send      (nxt.h_send),
    .offset    (hs_off_nxt),
    .cnt       (hc),
    .cnt_nxt   (hc_nxt),
    .blank     (hblank),
    .blank_nxt (hblank_nxt),
    .sync      (hsync),
    .last      (h_last)
  );

  vtg_axis_counter #(.W(VW)) u_v (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce_pix),
    .inc       (h_last),
    .total     (v_total_eff),
    .bstart    (nxt.v_bstart),
    .sstart    (nxt.v_sstart),
    .send      (nxt.v_send),
    .offset    (vs_off_nxt),
    .cnt       (vc),
    .cnt_nxt   (vc_nxt),
    .blank     (vblank),
    .blank_nxt (vblank_nxt),
    .sync      (vsync),
    .last      (v_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce_pix) begin
      de          <= ~(hblank_nxt | vblank_nxt);
      line_start  <= (hc_nxt == '0);
      frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: reset, default raster, set reload/reject, trims, ce gating.
module tb_video_timing_gen;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ce_pix = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [9:0]        cfg_h_total = '0, cfg_h_bstart = '0, cfg_h_sstart = '0, cfg_h_send = '0;
  logic [9:0]        cfg_v_total = '0, cfg_v_bstart = '0, cfg_v_sstart = '0, cfg_v_send = '0;
  logic signed [3:0] hs_offset = '0, vs_offset = '0;
  logic              cfg_err;
  logic [9:0]        hc, vc;
  logic              hblank, vblank, de, hsync, vsync, line_start, frame_start;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  video_timing_gen #(.HW(10), .VW(10)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_total(cfg_h_total), .cfg_h_bstart(cfg_h_bstart), .cfg_h_sstart(cfg_h_sstart),
    .cfg_h_send(cfg_h_send), .cfg_v_total(cfg_v_total), .cfg_v_bstart(cfg_v_bstart),
    .cfg_v_sstart(cfg_v_sstart), .cfg_v_send(cfg_v_send), .hs_offset(hs_offset),
    .vs_offset(vs_offset), .cfg_err(cfg_err), .hc(hc), .vc(vc), .hblank(hblank), .vblank(vblank),
    .de(de), .hsync(hsync), .vsync(vsync), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic offer(input int ht, input int hb, input int hs, input int he,
                       input int vt, input int vb, input int vs, input int ve);
    cfg_h_total = 10'(ht); cfg_h_bstart = 10'(hb); cfg_h_sstart = 10'(hs); cfg_h_send = 10'(he);
    cfg_v_total = 10'(vt); cfg_v_bstart = 10'(vb); cfg_v_sstart = 10'(vs); cfg_v_send = 10'(ve);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic run_to(input int x, input int y, input string name);
    int n = 0;
    while (!(hc == 10'(x) && vc == 10'(y)) && n < 130000) begin
      step();
      n++;
    end
    checks++;
    if (!(hc == 10'(x) && vc == 10'(y)))
      $display("FAIL %s timeout: at hc=%0d vc=%0d, wanted hc=%0d vc=%0d", name, hc, vc, x, y);
    else passes++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce_pix = 1'b0; cfg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hc !== 10'd0) $display("FAIL reset hc: got %0d want 0", hc); else passes++;
    checks++; if (vc !== 10'd0) $display("FAIL reset vc: got %0d want 0", vc); else passes++;
    checks++; if (hblank !== 1'b0 || vblank !== 1'b0) $display("FAIL reset blank: got %b%b want 00", hblank, vblank); else passes++;
    checks++; if (de !== 1'b1) $display("FAIL reset de: got %b want 1", de); else passes++;
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) $display("FAIL reset sync: got %b%b want 11", hsync, vsync); else passes++;
    checks++; if (line_start !== 1'b0 || frame_start !== 1'b0) $display("FAIL reset starts: got %b%b want 00", line_start, frame_start); else passes++;
    checks++; if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) $display("FAIL reset cfg: ready=%b err=%b want 1/0", cfg_ready, cfg_err); else passes++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ce_pix = 1'b1;
    cyc = 0;
  endtask

  task automatic test_default_line();
    for (int n = 1; n <= 450; n++) begin
      int e;
      step();
      e = n % 450;
      checks++; if (hc !== 10'(e)) $display("FAIL dline hc: got %0d want %0d", hc, e); else passes++;
      checks++; if (vc !== 10'(n / 450)) $display("FAIL dline vc: got %0d want %0d", vc, n / 450); else passes++;
      checks++; if (hblank !== (e >= 320)) $display("FAIL dline hblank hc=%0d: got %b want %b", e, hblank, e >= 320); else passes++;
      checks++; if (de !== (e < 320)) $display("FAIL dline de hc=%0d: got %b want %b", e, de, e < 320); else passes++;
      checks++; if (hsync !== !(e >= 360 && e < 380)) $display("FAIL dline hsync hc=%0d: got %b", e, hsync); else passes++;
      checks++; if (line_start !== (e == 0)) $display("FAIL dline line_start hc=%0d: got %b", e, line_start); else passes++;
      checks++; if (frame_start !== 1'b0) $display("FAIL dline frame_start hc=%0d: got %b want 0", e, frame_start); else passes++;
    end
  endtask

  task automatic test_cfg_reject();
    offer(450, 320, 320, 380, 270, 240, 250, 253);
    checks++; if (cfg_err !== 1'b1) $display("FAIL reject err pulse: got %b want 1", cfg_err); else passes++;
    checks++; if (cfg_ready !== 1'b1) $display("FAIL reject ready: got %b want 1", cfg_ready); else passes++;
    step();
    checks++; if (cfg_err !== 1'b0) $display("FAIL reject err width: got %b want 0", cfg_err); else passes++;
    checks++; if (cfg_ready !== 1'b1) $display("FAIL reject ready after: got %b want 1", cfg_ready); else passes++;
  endtask

  task automatic test_offset_midframe();
    hs_offset = -4'sd3;
    run_to(0, 3, "offset line");
    for (int n = 1; n < 450; n++) begin
      step();
      checks++; if (hc !== 10'(n)) $display("FAIL offset cur hc: got %0d want %0d", hc, n); else passes++;
      checks++; if (hsync !== !(n >= 360 && n < 380)) $display("FAIL offset cur hsync hc=%0d: got %b", n, hsync); else passes++;
    end
  endtask

  task automatic test_cfg_apply();
    offer(256, 200, 220, 240, 262, 224, 230, 233);
    checks++; if (cfg_ready !== 1'b0) $display("FAIL apply ready fall: got %b want 0", cfg_ready); else passes++;
    run_to(449, 239, "vblank edge");
    checks++; if (vblank !== 1'b0) $display("FAIL vblank at 239: got %b want 0", vblank); else passes++;
    checks++; if (cfg_ready !== 1'b0) $display("FAIL apply ready mid: got %b want 0", cfg_ready); else passes++;
    step();
    checks++; if (vc !== 10'd240 || hc !== 10'd0) $display("FAIL vblank pos: got %0d/%0d want 0/240", hc, vc); else passes++;
    checks++; if (vblank !== 1'b1 || de !== 1'b0) $display("FAIL vblank at 240: got vb=%b de=%b want 1/0", vblank, de); else passes++;
    run_to(449, 249, "vsync start");
    checks++; if (vsync !== 1'b1) $display("FAIL vsync at 249: got %b want 1", vsync); else passes++;
    step();
    checks++; if (vsync !== 1'b0) $display("FAIL vsync at 250: got %b want 0", vsync); else passes++;
    run_to(449, 252, "vsync end");
    checks++; if (vsync !== 1'b0) $display("FAIL vsync at 252: got %b want 0", vsync); else passes++;
    step();
    checks++; if (vsync !== 1'b1) $display("FAIL vsync at 253: got %b want 1", vsync); else passes++;
    run_to(449, 269, "frame end");
    checks++; if (vblank !== 1'b1 || cfg_ready !== 1'b0) $display("FAIL frame end: vb=%b ready=%b want 1/0", vblank, cfg_ready); else passes++;
    step();
    checks++; if (hc !== 10'd0 || vc !== 10'd0) $display("FAIL wrap pos: got %0d/%0d want 0/0", hc, vc); else passes++;
    checks++; if (frame_start !== 1'b1 || line_start !== 1'b1) $display("FAIL wrap starts: got %b%b want 11", frame_start, line_start); else passes++;
    checks++; if (cfg_ready !== 1'b1) $display("FAIL apply ready rise: got %b want 1", cfg_ready); else passes++;
    checks++; if (vblank !== 1'b0 || de !== 1'b1) $display("FAIL wrap blank: vb=%b de=%b want 0/1", vblank, de); else passes++;
    checks++; if (cyc !== 121500) $display("FAIL frame period: got %0d clks want 121500", cyc); else passes++;
    for (int n = 1; n <= 256; n++) begin
      int e;
      step();
      e = n % 256;
      checks++; if (hc !== 10'(e)) $display("FAIL new line hc: got %0d want %0d", hc, e); else passes++;
      checks++; if (vc !== 10'(n / 256)) $display("FAIL new line vc: got %0d want %0d", vc, n / 256); else passes++;
      checks++; if (hblank !== (e >= 200)) $display("FAIL new hblank hc=%0d: got %b", e, hblank); else passes++;
      checks++; if (hsync !== !(e >= 217 && e < 237)) $display("FAIL new hsync trimmed hc=%0d: got %b", e, hsync); else passes++;
      checks++; if (frame_start !== 1'b0) $display("FAIL new frame_start hc=%0d: got %b want 0", e, frame_start); else passes++;
    end
  endtask

  task automatic test_ce_quarter();
    for (int k = 0; k < 1024; k++) begin
      int en, e;
      ce_pix = ((k % 4) == 3);
      step();
      en = (k + 1) / 4;
      e = en % 256;
      checks++; if (hc !== 10'(e)) $display("FAIL ce4 hc k=%0d: got %0d want %0d", k, hc, e); else passes++;
      checks++; if (vc !== 10'(1 + en / 256)) $display("FAIL ce4 vc k=%0d: got %0d want %0d", k, vc, 1 + en / 256); else passes++;
      checks++; if (hblank !== (e >= 200)) $display("FAIL ce4 hblank k=%0d: got %b", k, hblank); else passes++;
      checks++; if (hsync !== !(e >= 217 && e < 237)) $display("FAIL ce4 hsync k=%0d: got %b", k, hsync); else passes++;
      checks++; if (line_start !== (e == 0)) $display("FAIL ce4 line_start k=%0d: got %b", k, line_start); else passes++;
    end
    ce_pix = 1'b0;
    offer(256, 200, 200, 240, 262, 224, 230, 233);
    checks++; if (cfg_err !== 1'b1) $display("FAIL ce0 reject err: got %b want 1", cfg_err); else passes++;
    checks++; if (hc !== 10'd0 || vc !== 10'd2) $display("FAIL ce0 hold: got %0d/%0d want 0/2", hc, vc); else passes++;
    step();
    checks++; if (cfg_err !== 1'b0) $display("FAIL ce0 err width: got %b want 0", cfg_err); else passes++;
  endtask

  task automatic test_reset_pending();
    ce_pix = 1'b1;
    offer(10, 6, 7, 8, 6, 3, 4, 5);
    checks++; if (cfg_ready !== 1'b0) $display("FAIL pend ready: got %b want 0", cfg_ready); else passes++;
    repeat (3) step();
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (hc !== 10'd0 || vc !== 10'd0) $display("FAIL async reset pos: got %0d/%0d want 0/0", hc, vc); else passes++;
    checks++; if (cfg_ready !== 1'b1) $display("FAIL async reset ready: got %b want 1", cfg_ready); else passes++;
    checks++; if (hsync !== 1'b1 || de !== 1'b1 || hblank !== 1'b0) $display("FAIL async reset outs: hs=%b de=%b hb=%b", hsync, de, hblank); else passes++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int n = 1; n <= 450; n++) begin
      int e;
      step();
      e = n % 450;
      checks++; if (hc !== 10'(e)) $display("FAIL post-reset hc: got %0d want %0d", hc, e); else passes++;
      checks++; if (hblank !== (e >= 320)) $display("FAIL post-reset hblank hc=%0d: got %b", e, hblank); else passes++;
      checks++; if (hsync !== !(e >= 360 && e < 380)) $display("FAIL post-reset hsync hc=%0d: got %b", e, hsync); else passes++;
      checks++; if (cfg_ready !== 1'b1) $display("FAIL post-reset ready hc=%0d: got %b", e, cfg_ready); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_cfg_reject();
    test_offset_midframe();
    test_cfg_apply();
    test_ce_quarter();
    test_reset_pending();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The module SHALL have parameters: HW, default 10, horizontal counter width; VW, default 10, vertical counter width.
REQ-002 The module SHALL have port clk, input, 1, sole clock.
REQ-003 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port ce_pix, input, 1, pixel clock enable; all counting and decoding advance only when high.
REQ-005 The module SHALL have port cfg_valid, input, 1, timing-set offer.
REQ-006 The module SHALL have port cfg_ready, output, 1, no set pending.
REQ-007 The module SHALL have ports cfg_h_total, cfg_h_bstart, cfg_h_sstart, cfg_h_send, input, HW each, horizontal timing set.
REQ-008 The module SHALL have ports cfg_v_total, cfg_v_bstart, cfg_v_sstart, cfg_v_send, input, VW each, vertical timing set.
REQ-009 The module SHALL have ports hs_offset and vs_offset, input, signed 4 each, sync position trims.
REQ-010 The module SHALL have port cfg_err, output, 1, one-clk pulse on a rejected set.
REQ-011 The module SHALL have ports hc, output, HW, and vc, output, VW, pixel and line position.
REQ-012 The module SHALL have ports hblank, vblank and de, output, 1 each; de = not hblank and not vblank.
REQ-013 The module SHALL have ports hsync and vsync, output, 1 each; both active-low.
REQ-014 The module SHALL have ports line_start and frame_start, output, 1 each; each pulses for one ce_pix-qualified clk.

Function
REQ-015 The module SHALL count hc 0..h_total-1; it SHALL wrap to 0 and advance vc; vc SHALL count 0..v_total-1 and wrap to 0.
REQ-016 hblank SHALL equal (hc >= h_bstart), vblank SHALL equal (vc >= v_bstart), and all outputs SHALL be registered and aligned with hc/vc with zero skew.
REQ-017 hsync SHALL be 0 iff h_sstart+hs_offset <= hc < h_send+hs_offset, and vsync SHALL use the same rule with vc and vs_offset; sums SHALL be evaluated signed at HW+1/VW+1 bits, and an out-of-range window SHALL clip naturally.
REQ-018 hs_offset and vs_offset SHALL be sampled only at frame wrap, so a mid-frame change takes effect next frame.
REQ-019 line_start SHALL be 1 when hc==0, and frame_start SHALL be 1 when hc==0 and vc==0.
REQ-020 A set SHALL be accepted when cfg_valid and cfg_ready are both 1; cfg_ready SHALL fall the next clk and stay low until the set is applied.
REQ-021 An accepted set SHALL be applied at frame wrap (hc==h_total-1, vc==v_total-1, ce_pix); cfg_ready SHALL rise the same clk.
REQ-022 A set SHALL be valid only if bstart < sstart < send < total in both axes; an invalid set SHALL be dropped, cfg_err SHALL pulse the clk after offer, and cfg_ready SHALL stay 1.
REQ-023 When ce_pix is 0, all outputs SHALL hold their values; the cfg handshake SHALL still operate.

Reset
REQ-024 reset_n low SHALL asynchronously set hc=0, vc=0, hblank=0, vblank=0, de=1, hsync=1, vsync=1, line_start=0, frame_start=0, cfg_ready=1, cfg_err=0, and discard any pending set.
REQ-025 Active timing SHALL reset to h 450/320/360/380 and v 270/240/250/253, with offsets 0.

Configuration
REQ-026 With VTG_FIELD_EN defined, the module SHALL add output field (1 bit, reset 0), toggle it at each frame wrap, and use v_total+1 lines in frames where field=1.
REQ-027 Without VTG_FIELD_EN, no field port SHALL exist and every frame SHALL be v_total lines.

Structure
REQ-028 Package video_timing_pkg SHALL hold a timing-set struct typedef and the default 320x240 constants.
REQ-029 The block SHALL contain one sub-module, vtg_axis_counter, instantiated once for H and once for V with generic width; it provides counter, blank, sync and wrap decode.

Verification
REQ-030 Reset then ce_pix=1 -> hsync low for hc 360..379, vblank rises at vc=240, frame period 450*270 clks.
REQ-031 ce_pix high every 4th clk -> frame period 4*450*270 clks; outputs stable between enables.
REQ-032 Offer set 256/200/220/240 and 262/224/230/233 mid-frame -> cfg_ready=0 until wrap; next frame uses the new totals.
REQ-033 Offer set with h_sstart=h_bstart -> cfg_err single pulse, cfg_ready stays 1, timing unchanged.
REQ-034 hs_offset=-3 changed mid-frame -> current frame hsync at hc 360..379, next frame at hc 357..376.
REQ-035 Assert reset_n low mid-line with a set pending -> immediate defaults, cfg_ready=1, pending set lost.
